mem_b_arbiter: RTL and testbench

Two-requester arbiter for the main memory B port (13-bit word address, 32-bit data, 1-cycle BRAM read latency). It sits in front of `mem_b_we/addr/din/dout` of the simple cache and shares that port between requester 0 (host loader) and requester 1 (debug/trace reader). It grants ownership of the port for bursts of up to `MAX_BURST` beats, using round-robin between bursts. It returns read data to the owning requester with a registered valid.

---
 rtl/mem_b_arb_pkg.sv | 18 +
 rtl/mem_b_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_b_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_b_arb_pkg.sv
// Shared types and constants for the main-memory port B arbiter.
package mem_b_arb_pkg;

  // Arbiter ownership states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  // Requester IDs: 0 = host loader, 1 = debug/trace reader.
  localparam logic RQ0 = 1'b0;
  localparam logic RQ1 = 1'b1;

  // Idle cycles an owner may stall before its burst is force-released.
  localparam logic [3:0] TIMEOUT_LIMIT = 4'd15;

endpackage

// File: rtl/mem_b_arbiter.sv
// Two-requester burst arbiter for main memory port B (1-cycle BRAM read latency).
// Ownership is granted per burst with round-robin between bursts and one bubble
// cycle between grants. Optional macro MEM_B_ARB_TIMEOUT_EN adds a stall
// timeout that force-releases a locked burst and pulses arb_err.
module mem_b_arbiter
  import mem_b_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 13,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rq0_req,
  input  logic              rq0_we,
  input  logic [ADDR_W-1:0] rq0_addr,
  input  logic [DATA_W-1:0] rq0_din,
  input  logic              rq0_last,
  input  logic              rq1_req,
  input  logic              rq1_we,
  input  logic [ADDR_W-1:0] rq1_addr,
  input  logic [DATA_W-1:0] rq1_din,
  input  logic              rq1_last,
  output logic              rq0_gnt,
  output logic              rq1_gnt,
  output logic              rq0_rvalid,
  output logic              rq1_rvalid,
  output logic [DATA_W-1:0] rq0_rdata,
  output logic [DATA_W-1:0] rq1_rdata,
  output logic              mem_b_we,
  output logic [ADDR_W-1:0] mem_b_addr,
  output logic [DATA_W-1:0] mem_b_din,
  input  logic [DATA_W-1:0] mem_b_dout,
  output logic              arb_err
);

  localparam int unsigned CntW = $clog2(MAX_BURST) + 1;
  localparam logic [CntW-1:0] BurstEnd = CntW'(MAX_BURST - 1);

  arb_state_e        state_q, state_d;
  logic              rr_last_q, rr_last_d;
  logic [CntW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [ADDR_W-1:0] held_addr_q;
  logic [DATA_W-1:0] held_din_q;
  logic              rd_pend_q, rd_id_q;

  logic              owning, own_id, beat;
  logic              owner_req, owner_we, owner_last;
  logic [ADDR_W-1:0] owner_addr;
  logic [DATA_W-1:0] owner_din;

`ifdef MEM_B_ARB_TIMEOUT_EN
  logic [3:0] idle_cnt_q, idle_cnt_d;
  logic       arb_err_q, arb_err_d;
`endif

  // Select the current owner's beat fields; a beat is an owner request while owning.
  always_comb begin
    owning     = (state_q != IDLE);
    own_id     = (state_q == OWN1) ? RQ1 : RQ0;
    owner_req  = (own_id == RQ1) ? rq1_req  : rq0_req;
    owner_we   = (own_id == RQ1) ? rq1_we   : rq0_we;
    owner_addr = (own_id == RQ1) ? rq1_addr : rq0_addr;
    owner_din  = (own_id == RQ1) ? rq1_din  : rq0_din;
    owner_last = (own_id == RQ1) ? rq1_last : rq0_last;
    // Reset aborts the cycle immediately so nothing is accepted or delivered.
    beat       = owning && owner_req && !rst;
  end

  // Grants, memory port drive and read-data return.
  always_comb begin
    rq0_gnt    = beat && (own_id == RQ0);
    rq1_gnt    = beat && (own_id == RQ1);
    mem_b_we   = beat && owner_we;
    mem_b_addr = owning ? owner_addr : held_addr_q;
    mem_b_din  = owning ? owner_din  : held_din_q;
    rq0_rvalid = rd_pend_q && !rst && (rd_id_q == RQ0);
    rq1_rvalid = rd_pend_q && !rst && (rd_id_q == RQ1);
    rq0_rdata  = rq0_rvalid ? mem_b_dout : '0;
    rq1_rdata  = rq1_rvalid ? mem_b_dout : '0;
  end

  // Next-state: round-robin pick in IDLE, beat counting and release while owning.
  always_comb begin
    state_d    = state_q;
    rr_last_d  = rr_last_q;
    beat_cnt_d = beat_cnt_q;
`ifdef MEM_B_ARB_TIMEOUT_EN
    idle_cnt_d = idle_cnt_q;
    arb_err_d  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef MEM_B_ARB_TIMEOUT_EN
        idle_cnt_d = '0;
`endif
        // On a tie the requester that did not own last wins.
        if (rq0_req && (!rq1_req || rr_last_q == RQ1)) begin
          state_d    = OWN0;
          rr_last_d  = RQ0;
          beat_cnt_d = '0;
        end else if (rq1_req) begin
          state_d    = OWN1;
          rr_last_d  = RQ1;
          beat_cnt_d = '0;
        end
      end
      OWN0, OWN1: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q + CntW'(1);
          if (owner_last || beat_cnt_q == BurstEnd) state_d = IDLE;
`ifdef MEM_B_ARB_TIMEOUT_EN
          idle_cnt_d = '0;
        end else if (idle_cnt_q == TIMEOUT_LIMIT - 4'd1) begin
          // This stall cycle brings the counter to the limit: give the port up.
          state_d    = IDLE;
          idle_cnt_d = '0;
          arb_err_d  = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q + 4'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, held memory fields and pending-read tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_last_q   <= RQ1;
      beat_cnt_q  <= '0;
      held_addr_q <= '0;
      held_din_q  <= '0;
      rd_pend_q   <= 1'b0;
      rd_id_q     <= RQ0;
`ifdef MEM_B_ARB_TIMEOUT_EN
      idle_cnt_q  <= '0;
      arb_err_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      beat_cnt_q <= beat_cnt_d;
      if (owning) begin
        held_addr_q <= owner_addr;
        held_din_q  <= owner_din;
      end
      rd_pend_q  <= beat && !owner_we;
      rd_id_q    <= own_id;
`ifdef MEM_B_ARB_TIMEOUT_EN
      idle_cnt_q <= idle_cnt_d;
      arb_err_q  <= arb_err_d;
`endif
    end
  end

`ifdef MEM_B_ARB_TIMEOUT_EN
  assign arb_err = arb_err_q;
`else
  assign arb_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_b_arbiter.sv
// Self-checking bench for mem_b_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// burst-level reference model. Honours MEM_B_ARB_TIMEOUT_EN if defined.
module tb_mem_b_arbiter;
  localparam int AW = 13;
  localparam int DW = 32;
  localparam int MB = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          rq0_req = 0, rq0_we = 0, rq0_last = 0;
  logic          rq1_req = 0, rq1_we = 0, rq1_last = 0;
  logic [AW-1:0] rq0_addr = '0, rq1_addr = '0;
  logic [DW-1:0] rq0_din = '0, rq1_din = '0;
  logic          rq0_gnt, rq1_gnt, rq0_rvalid, rq1_rvalid, mem_b_we, arb_err;
  logic [DW-1:0] rq0_rdata, rq1_rdata, mem_b_din, mem_b_dout;
  logic [AW-1:0] mem_b_addr;

  mem_b_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .rq0_req(rq0_req), .rq0_we(rq0_we), .rq0_addr(rq0_addr), .rq0_din(rq0_din),
    .rq0_last(rq0_last),
    .rq1_req(rq1_req), .rq1_we(rq1_we), .rq1_addr(rq1_addr), .rq1_din(rq1_din),
    .rq1_last(rq1_last),
    .rq0_gnt(rq0_gnt), .rq1_gnt(rq1_gnt), .rq0_rvalid(rq0_rvalid), .rq1_rvalid(rq1_rvalid),
    .rq0_rdata(rq0_rdata), .rq1_rdata(rq1_rdata),
    .mem_b_we(mem_b_we), .mem_b_addr(mem_b_addr), .mem_b_din(mem_b_din),
    .mem_b_dout(mem_b_dout), .arb_err(arb_err)
  );

  // Preloaded memory contents for never-written words.
  function automatic logic [31:0] pre(input int a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  // Write-first BRAM with 1-cycle read latency on port B.
  logic [DW-1:0] bram [0:8191];
  bit            bwr  [0:8191];
  always @(posedge clk) begin
    if (mem_b_we) begin
      bram[mem_b_addr] <= mem_b_din;
      bwr[mem_b_addr]  <= 1'b1;
      mem_b_dout       <= mem_b_din;
    end else begin
      mem_b_dout <= bwr[mem_b_addr] ? bram[mem_b_addr] : pre(int'(mem_b_addr));
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int            own = -1;   // current burst owner, -1 when nobody owns the port
  bit            rr = 1'b1;  // last owner
  int            beats = 0;  // beats taken in the current grant
  int            idle = 0;   // consecutive stalled cycles of the owner
  bit            rdp = 1'b0; // a read result is due this cycle
  int            rdi = 0;
  logic [31:0]   rdd = '0;
  bit            err = 1'b0;
  logic [AW-1:0] haddr = '0;
  logic [DW-1:0] hdin = '0;
  logic [DW-1:0] shadow [0:8191];
  bit            swr    [0:8191];
  bit            model_ok = 1'b0;

  function automatic bit mreq(input int i);  return (i == 1) ? rq1_req : rq0_req;   endfunction
  function automatic bit mwe(input int i);   return (i == 1) ? rq1_we : rq0_we;     endfunction
  function automatic bit mlast(input int i); return (i == 1) ? rq1_last : rq0_last; endfunction
  function automatic logic [AW-1:0] maddr(input int i);
    return (i == 1) ? rq1_addr : rq0_addr;
  endfunction
  function automatic logic [DW-1:0] mdin(input int i);
    return (i == 1) ? rq1_din : rq0_din;
  endfunction

  // Model update at each rising edge from the inputs of the ending cycle.
  initial begin
    bit b;
    int a;
    forever begin
      @(posedge clk);
      b = (own >= 0) && mreq(own) && !rst;
      if (rst) begin
        own = -1; rr = 1'b1; beats = 0; idle = 0; rdp = 1'b0; err = 1'b0;
        haddr = '0; hdin = '0; model_ok = 1'b1;
      end else begin
        err = 1'b0;
        rdp = 1'b0;
        if (own < 0) begin
          if (rq0_req && rq1_req) own = rr ? 0 : 1;
          else if (rq0_req) own = 0;
          else if (rq1_req) own = 1;
          if (own >= 0) begin rr = own[0]; beats = 0; idle = 0; end
        end else begin
          haddr = maddr(own);
          hdin  = mdin(own);
          if (b) begin
            a = int'(maddr(own));
            idle = 0;
            if (mwe(own)) begin
              shadow[a] = mdin(own);
              swr[a] = 1'b1;
            end else begin
              rdp = 1'b1;
              rdi = own;
              rdd = swr[a] ? shadow[a] : pre(a);
            end
            beats++;
            if (mlast(own) || beats == MB) own = -1;
          end else begin
`ifdef MEM_B_ARB_TIMEOUT_EN
            idle++;
            if (idle == 15) begin own = -1; err = 1'b1; idle = 0; end
`endif
          end
        end
      end
    end
  end

  // Compare process: every cycle, well after inputs settle and before the edge.
  initial begin
    bit b, rv0, rv1;
    forever begin
      @(negedge clk);
      #2;
      if (model_ok) begin
        b   = (own >= 0) && mreq(own) && !rst;
        rv0 = rdp && !rst && (rdi == 0);
        rv1 = rdp && !rst && (rdi == 1);
        chk("m_gnt0", rq0_gnt, b && own == 0);
        chk("m_gnt1", rq1_gnt, b && own == 1);
        chk("m_we", mem_b_we, b && mwe(own));
        chk("m_addr", mem_b_addr, (own >= 0) ? maddr(own) : haddr);
        chk("m_din", mem_b_din, (own >= 0) ? mdin(own) : hdin);
        chk("m_rvalid0", rq0_rvalid, rv0);
        chk("m_rvalid1", rq1_rvalid, rv1);
        chk("m_rdata0", rq0_rdata, rv0 ? rdd : 32'h0);
        chk("m_rdata1", rq1_rdata, rv1 ? rdd : 32'h0);
        chk("m_arb_err", arb_err, err);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drv(input int r, input bit req, input bit we, input int a,
                     input logic [31:0] d, input bit last);
    if (r == 0) begin
      rq0_req = req; rq0_we = we; rq0_addr = AW'(a); rq0_din = d; rq0_last = last;
    end else begin
      rq1_req = req; rq1_we = we; rq1_addr = AW'(a); rq1_din = d; rq1_last = last;
    end
  endtask

  // Returns just after a falling edge with reset released: that cycle is cycle 0.
  task automatic do_reset();
    @(negedge clk);
    rq0_req = 0; rq1_req = 0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int done0;
    bit g0p, g1p, r0done;
    int rem [2];
    bit gp [2];

    // Single write with last.
    do_reset();
    drv(0, 1, 1, 'h010, 32'hDEADBEEF, 1);
    #1 chk("s1_c0_gnt0", rq0_gnt, 0);
    @(negedge clk); #1;
    chk("s1_c1_gnt0", rq0_gnt, 1);
    chk("s1_c1_we", mem_b_we, 1);
    chk("s1_c1_addr", mem_b_addr, 'h010);
    chk("s1_c1_din", mem_b_din, 32'hDEADBEEF);
    @(negedge clk); #1;
    chk("s1_c2_gnt0", rq0_gnt, 0);
    chk("s1_c2_we", mem_b_we, 0);
    chk("s1_c2_addr_hold", mem_b_addr, 'h010);
    @(negedge clk); #1 chk("s1_c3_gnt0", rq0_gnt, 1);
    @(negedge clk); drv(0, 0, 0, 0, 0, 0);

    // Tie after reset: rq0 first, bubble, then rq1.
    do_reset();
    drv(0, 1, 1, 'h020, 32'h11111111, 0);
    drv(1, 1, 0, 'h100, 0, 1);
    #1 chk("s2_c0_gnt0", rq0_gnt, 0);
    @(negedge clk); #1;
    chk("s2_c1_gnt0", rq0_gnt, 1);
    chk("s2_c1_gnt1", rq1_gnt, 0);
    @(negedge clk); drv(0, 1, 1, 'h021, 32'h22222222, 1);
    #1 chk("s2_c2_gnt0", rq0_gnt, 1);
    @(negedge clk); drv(0, 0, 0, 0, 0, 0);
    #1 chk("s2_c3_bubble", {rq0_gnt, rq1_gnt}, 2'b00);
    @(negedge clk); #1 chk("s2_c4_gnt1", rq1_gnt, 1);
    @(negedge clk); drv(1, 0, 0, 0, 0, 0);
    #1;
    chk("s2_c5_rvalid1", rq1_rvalid, 1);
    chk("s2_c5_rdata1", rq1_rdata, 32'hC0DE0100);

    // rq1 four-beat read burst from preloaded words.
    do_reset();
    drv(1, 1, 0, 'h100, 0, 0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c >= 2 && c <= 4) drv(1, 1, 0, 'h100 + c - 1, 0, (c - 1) == 3);
      if (c == 5) drv(1, 0, 0, 0, 0, 0);
      #1;
      if (c <= 4) begin
        chk("s3_gnt1", rq1_gnt, 1);
        chk("s3_addr", mem_b_addr, 'h100 + c - 1);
      end
      if (c >= 2) begin
        chk("s3_rvalid1", rq1_rvalid, 1);
        chk("s3_rdata1", rq1_rdata, pre('h100 + c - 2));
        chk("s3_rvalid0", rq0_rvalid, 0);
      end
    end

    // rq0 asks for 12 beats: cut after 8, rq1 served, then rq0 resumes.
    do_reset();
    drv(0, 1, 1, 'h040, 32'h0A0A0A0A, 0);
    drv(1, 1, 1, 'h050, 32'h0B0B0B0B, 1);
    done0 = 0; g0p = 0; g1p = 0;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (g0p) done0++;
      if (g1p) rq1_req = 0;
      rq0_req  = (done0 < 12);
      rq0_last = (done0 == 11);
      #1;
      g0p = rq0_gnt;
      g1p = rq1_gnt;
      if (c == 8) chk("s4_c8_gnt0", rq0_gnt, 1);
      if (c == 9) chk("s4_c9_bubble", {rq0_gnt, rq1_gnt}, 2'b00);
      if (c == 10) chk("s4_c10_gnt1", {rq0_gnt, rq1_gnt}, 2'b01);
      if (c == 11) chk("s4_c11_bubble", {rq0_gnt, rq1_gnt}, 2'b00);
      if (c == 12) chk("s4_c12_gnt0", rq0_gnt, 1);
    end
    chk("s4_rq0_beats", done0, 12);

    // Owner stalls 20 cycles without last while rq1 waits.
    do_reset();
    drv(0, 1, 1, 'h044, 32'h44444444, 0);
    drv(1, 1, 1, 'h054, 32'h55555555, 1);
    g1p = 0; g0p = 0; r0done = 0;
    for (int c = 1; c <= 26; c++) begin
      @(negedge clk);
      if (g1p) rq1_req = 0;
      if (g0p && c > 22) r0done = 1;
      rq0_req  = (c == 1) || (c >= 22 && !r0done);
      rq0_last = (c >= 22);
      #1;
      g0p = rq0_gnt;
      g1p = rq1_gnt;
`ifdef MEM_B_ARB_TIMEOUT_EN
      if (c == 16) chk("s5_c16_err", arb_err, 0);
      if (c == 17) chk("s5_c17_err", {arb_err, rq1_gnt}, 2'b10);
      if (c == 18) chk("s5_c18_gnt1", {arb_err, rq1_gnt}, 2'b01);
`else
      if (c >= 2 && c <= 21) chk("s5_locked", {arb_err, rq1_gnt}, 2'b00);
      if (c == 24) chk("s5_c24_gnt1", rq1_gnt, 1);
`endif
    end

    // Reset right after a read beat: the result is dropped.
    do_reset();
    drv(0, 1, 0, 'h100, 0, 1);
    @(negedge clk); #1 chk("s6_c1_gnt0", rq0_gnt, 1);
    @(negedge clk);
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0);
    #1 chk("s6_c2_rvalid0", rq0_rvalid, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("s6_c3_rvalid", {rq0_rvalid, rq1_rvalid, rq0_gnt, rq1_gnt, mem_b_we, arb_err}, 6'b0);
    chk("s6_c3_addr", mem_b_addr, 0);
    chk("s6_c3_din", mem_b_din, 0);
    chk("s6_c3_rdata", {rq0_rdata, rq1_rdata}, 64'h0);

    // Random traffic: bursts of 1..12 beats, random stalls, rare resets.
    do_reset();
    rem[0] = 0; rem[1] = 0; gp[0] = 0; gp[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c != 0) @(negedge clk);
      rst = ($urandom_range(0, 599) == 0);
      for (int i = 0; i < 2; i++) begin
        bit newb;
        newb = 0;
        if (gp[i]) begin rem[i]--; newb = (rem[i] > 0); end
        if (rem[i] == 0 && $urandom_range(0, 3) == 0) begin
          rem[i] = $urandom_range(1, 12);
          newb = 1;
        end
        if (newb)
          drv(i, 1, $urandom_range(0, 1), 'h040 + $urandom_range(0, 15), $urandom, rem[i] == 1);
        if (i == 0) rq0_req = (rem[0] > 0) && ($urandom_range(0, 7) != 0);
        else        rq1_req = (rem[1] > 0) && ($urandom_range(0, 7) != 0);
      end
      #1;
      gp[0] = rq0_gnt;
      gp[1] = rq1_gnt;
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
